// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with ready/valid handshakes, a 2-entry skid buffer,
// flush with bubble injection and a saturating backpressure counter.
module pipe_stage_skid #(
  parameter int unsigned              PC_WIDTH     = 16,
  parameter int unsigned              INSTR_WIDTH  = 16,
  parameter int unsigned              CTRL_WIDTH   = 32,
  parameter logic [INSTR_WIDTH-1:0]   BUBBLE_INSTR = 16'h0000,
  parameter int unsigned              CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic [INSTR_WIDTH-1:0] instruction_in,
  input  logic [CTRL_WIDTH-1:0]  control_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic [CTRL_WIDTH-1:0]  control_out,
  output logic [1:0]             occupancy,
  output logic [CNT_WIDTH-1:0]   stall_count,
  input  logic                   clear_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid/ready are pure functions of the state register.
  localparam int unsigned PW = PC_WIDTH + INSTR_WIDTH + CTRL_WIDTH;
  localparam logic [PW-1:0] BUBBLE = {{PC_WIDTH{1'b0}}, BUBBLE_INSTR, {CTRL_WIDTH{1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        skid_q, skid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept, deliver;
  logic [PW-1:0]        in_payload;

  assign in_payload = {pc_in, instruction_in, control_in};
  assign accept     = in_valid & (state_q != FULL);
  assign deliver    = out_ready & (state_q != EMPTY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = in_payload;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            head_d = in_payload;
          end else if (accept) begin
            skid_d  = in_payload;
            state_d = FULL;
          end else if (deliver) begin
            head_d  = BUBBLE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            head_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // Counts presented-but-refused cycles, including on flush cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = '0;
    end else if ((state_q != EMPTY) && !out_ready && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign occupancy = state_q;
  assign stall_count = cnt_q;
  assign {pc_out, instruction_out, control_out} = head_q;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed IF/ID load-enable latch, for use between any two pipeline stages. It replaces the global `load` with per-stage ready/valid handshakes and a 2-entry skid buffer. Upstream therefore never needs a combinational stall path, and the stage still sustains one transfer per cycle. It adds flush with bubble injection and a saturating backpressure counter for performance debug.

Parameters:
PC_WIDTH, 16, width of pc payload
INSTR_WIDTH, 16, width of instruction payload
CTRL_WIDTH, 32, width of flattened control word payload
BUBBLE_INSTR, 16'h0000, instruction value presented when stage empty/flushed (LC-3b BR-never NOP)
CNT_WIDTH, 16, width of stall counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all held entries this cycle
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept; registered, equals (occupancy != 2)
pc_in  in  PC_WIDTH  upstream pc
instruction_in  in  INSTR_WIDTH  upstream instruction
control_in  in  CTRL_WIDTH  upstream control word
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream can accept
pc_out  out  PC_WIDTH  head entry pc
instruction_out  out  INSTR_WIDTH  head entry instruction
control_out  out  CTRL_WIDTH  head entry control word
occupancy  out  2  entries held: 0, 1 or 2
stall_count  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating
clear_count  in  1  synchronous zero of stall_count

Behaviour:
- Storage: head register (drives outputs) and skid register. State is EMPTY (0), ONE (1) or FULL (2); occupancy encodes the state.
- accept = in_valid & in_ready. deliver = out_valid & out_ready.
- out_valid = (state != EMPTY). in_ready = (state != FULL). Both come straight from the state register; no combinational path from in_* or out_ready to any output.
- Transitions when flush=0:
  - EMPTY: accept loads head from input, go to ONE. Otherwise stay.
  - ONE, accept & deliver: head <= input, stay ONE (full throughput).
  - ONE, accept & !deliver: skid <= input, go to FULL.
  - ONE, !accept & deliver: head <= bubble, go to EMPTY.
  - ONE, neither: hold.
  - FULL: in_ready=0, so no accept. deliver moves head <= skid and skid <= bubble, go to ONE. Otherwise hold.
- Ordering is strict FIFO. No entry is duplicated or lost except by flush.
- Bubble payload: pc=0, instruction=BUBBLE_INSTR, control=0. When out_valid=0, the head always holds the bubble.
- flush=1 (priority below reset, above everything else):
  - Next state is EMPTY; head and skid are set to bubble.
  - An input accepted on the flush cycle is dropped.
  - A deliver on the flush cycle counts as completed downstream, since its payload was valid and presented.
- Latency: an input accepted in cycle N appears on the outputs in cycle N+1 when the stage was EMPTY, or when it was ONE with a concurrent deliver.
- stall_count:
  - Increments by 1 in each cycle where out_valid & !out_ready, independent of flush.
  - Holds at all-ones (saturates, no wrap).
  - clear_count=1 forces it to 0 next cycle, overriding the increment.
- reset=1, sampled on a clk edge:
  - state EMPTY, head and skid bubble, out_valid=0, in_ready=1, occupancy=0, stall_count=0.
  - Reset mid-transfer discards all entries.
  - Inputs are ignored on the reset cycle.
- All widths are independent; no arithmetic on the payload.

Test Plan:
- Reset then idle: assert reset 2 cycles with in_valid=1 and pc_in=16'h1234 -> after release out_valid=0, in_ready=1, instruction_out=16'h0000, occupancy=0, stall_count=0.
- Streaming: out_ready=1, present pc 16'h3000/3002/3004 on consecutive cycles -> same values appear on pc_out one cycle later each, out_valid=1 continuously, occupancy stays 1.
- Backpressure skid: stream 16'h3000,3002; drop out_ready to 0 the cycle 3000 is presented -> 3002 captured in skid, occupancy=2, in_ready=0. Raise out_ready -> 3000 then 3002 delivered in order, no loss.
- Flush while FULL plus simultaneous input: occupancy=2, in_valid=1, flush=1 -> next cycle occupancy=0, out_valid=0, pc_out=0, instruction_out=BUBBLE_INSTR; the flushed input never appears.
- Counter saturation: CNT_WIDTH=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_count reaches 4'hF and stays. Pulse clear_count -> 0 next cycle, then resumes counting.
- Reset mid-operation: occupancy=2, then reset=1 for 1 cycle -> all outputs at reset values next cycle. Subsequent input 16'h4000 delivered normally with 1-cycle latency.
